d_branch_sched: RTL
===================

Name: d_branch_sched

Overview:
- Decode-stage branch scheduler for the D-stage equality comparator.
- Selects a forwarding source for each comparator operand.
- Decides the D-stage stall while an operand is still in flight.
- Converts the comparator's equality result into a taken decision for beq/bne.
- Sits between the D pipeline register, the E/M pipeline registers and the PC-select logic.

Parameters:
- MAX_STALL, 3: stall cycles for one branch before the watchdog error sets.
- TNEW_W, 2: width of the Tnew fields.
- CNT_W, 16: width of the statistics counters (only present with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- d_valid  in  1  D stage holds a valid instruction
- d_is_branch  in  1  the D instruction is beq or bne
- d_is_bne  in  1  1 = bne, 0 = beq
- d_rs  in  5  rs field of the D instruction
- d_rt  in  5  rt field of the D instruction
- e_wa  in  5  destination register in E (0 = none)
- e_tnew  in  TNEW_W  cycles until the E result is forwardable
- m_wa  in  5  destination register in M (0 = none)
- m_tnew  in  TNEW_W  cycles until the M result is forwardable
- cmp_eq  in  1  equality output of the comparator
- fwd_sel_rs  out  2  rs operand source: 0 = RF, 1 = E, 2 = M
- fwd_sel_rt  out  2  rt operand source, same encoding as fwd_sel_rs
- stall  out  1  freeze PC and the D register, bubble into E
- br_taken  out  1  redirect the PC to the branch target this cycle
- br_resolved  out  1  registered one-cycle pulse: a branch resolved in the previous cycle
- wd_err  out  1  sticky watchdog error

Behaviour:
- Branch operand Tuse is 0 for rs and rt.
- Hazard on rs: d_rs != 0 and ((d_rs == e_wa and e_tnew > 0) or (d_rs == m_wa and m_tnew > 0)). The rt hazard is defined the same way with d_rt.
- fwd_sel for each operand (combinational):
  - E (1) if the register != 0, equals e_wa, and e_tnew == 0;
  - else M (2) if it equals m_wa and m_tnew == 0;
  - else RF (0).
  - E has priority over M when both match.
- stall = d_valid & d_is_branch & (rs hazard | rt hazard). Combinational, same cycle.
- br_taken = d_valid & d_is_branch & ~stall & (cmp_eq ^ d_is_bne). Combinational; never asserted together with stall.
- Non-branch D instructions, or d_valid = 0: stall = 0, br_taken = 0, fwd_sel = 0, FSM returns to IDLE.
- FSM states:
  - IDLE: no branch held. Resolvable branch → stays in IDLE and the br_resolved flop is set for the next cycle. Hazarded branch → WAIT, stall_cnt = 1.
  - WAIT: branch held by stall. Hazard persists → stall_cnt increments, saturating at MAX_STALL+1. Hazard clears → RESOLVE.
  - RESOLVE: branch decided this cycle. Next state is IDLE. If a new hazarded branch is already present, go directly to WAIT with stall_cnt = 1.
- Watchdog: wd_err sets on the cycle stall_cnt would exceed MAX_STALL. It clears only on reset.
- br_resolved is high for exactly one cycle after any cycle in which br_taken was evaluated with stall = 0 and a valid branch present.
- Reset (asynchronous assert, synchronous deassert from the system): state = IDLE, stall_cnt = 0, br_resolved = 0, wd_err = 0, stats = 0.
  - Combinational outputs follow their inputs during reset, except that stall and br_taken are forced to 0.
  - Reset mid-stall abandons the branch; the pipeline refetches it.
- Register 0 never causes a hazard and never forwards.

Optional Feature:
- Macro BR_SCHED_STATS_EN.
- Defined: three CNT_W counters, readable through outputs stat_branches, stat_taken and stat_stall_cycles.
  - stat_branches: +1 per br_resolved pulse.
  - stat_taken: +1 per taken resolution.
  - stat_stall_cycles: +1 per stall cycle.
  - All three wrap modulo 2^CNT_W and reset to 0.
- Undefined: counters and their ports are absent. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - forwarding-select encodings FWD_RF = 0, FWD_E = 1, FWD_M = 2;
  - FSM state encodings IDLE, WAIT, RESOLVE;
  - TNEW width constant.
- One natural sub-module, d_fwd_pick: per-operand hazard and select logic, instantiated once for rs and once for rt.

Test Plan:
- No hazard: beq, rs = 8, rt = 9, e_wa = 0, m_wa = 0, cmp_eq = 1 → stall = 0, br_taken = 1, fwd = 0/0, br_resolved = 1 next cycle.
- E-stage forward: bne, rs = 8, e_wa = 8, e_tnew = 0, cmp_eq = 1 → fwd_sel_rs = 1, br_taken = 0.
- Load-use then M forward: rs = 8, e_wa = 8, e_tnew = 1 → stall = 1, state WAIT. Next cycle m_wa = 8, m_tnew = 0 → stall = 0, fwd_sel_rs = 2, resolves.
- Priority and $0: rs = 8 with e_wa = m_wa = 8 and both tnew = 0 → fwd_sel_rs = 1. rs = 0 with e_wa = 0, e_tnew = 2 → no stall.
- Watchdog: hold a hazard for MAX_STALL + 1 = 4 cycles → wd_err rises on cycle 4 and stays set after the hazard clears. Assert reset mid-stall → every registered output 0 immediately.
- Stats (BR_SCHED_STATS_EN): 3 branches (2 taken) with 1 stall cycle total → stat_branches = 3, stat_taken = 2, stat_stall_cycles = 1.

Source files
------------

// File: rtl/d_branch_sched_pkg.sv
// d_branch_sched_pkg
// Shared encodings for the decode-stage branch scheduler:
//   - forwarding-select codes driven on fwd_sel_rs / fwd_sel_rt
//   - scheduler FSM state codes
//   - default width of the Tnew fields coming from the E/M pipeline registers
// No ports; imported by d_fwd_pick and d_branch_sched.
package d_branch_sched_pkg;

  localparam int TNEW_WIDTH = 2;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESOLVE = 2'd2
  } br_state_e;

endpackage

// File: rtl/d_branch_sched_fwd_pick.sv
// d_fwd_pick
// Per-operand hazard detection and forwarding-source selection for one
// comparator operand of the D-stage branch comparator.
// Ports:
//   src      in  5       register number read by the D instruction
//   e_wa     in  5       destination register in E (0 = none)
//   e_tnew   in  TNEW_W  cycles until the E result is forwardable
//   m_wa     in  5       destination register in M (0 = none)
//   m_tnew   in  TNEW_W  cycles until the M result is forwardable
//   hazard   out 1       operand is still in flight (branch Tuse is 0)
//   fwd_sel  out 2       0 = RF, 1 = E, 2 = M
module d_fwd_pick
  import d_branch_sched_pkg::*;
#(
  parameter int TNEW_W = TNEW_WIDTH
) (
  input  logic [4:0]        src,
  input  logic [4:0]        e_wa,
  input  logic [TNEW_W-1:0] e_tnew,
  input  logic [4:0]        m_wa,
  input  logic [TNEW_W-1:0] m_tnew,
  output logic              hazard,
  output logic [1:0]        fwd_sel
);

  logic hit_e;
  logic hit_m;

  // $0 is hard-wired zero, so it never matches a producer.
  assign hit_e = (src != 5'd0) && (src == e_wa);
  assign hit_m = (src != 5'd0) && (src == m_wa);

  // Tuse is 0 for branch operands: any producer with Tnew > 0 is too late.
  assign hazard = (hit_e && (e_tnew != '0)) || (hit_m && (m_tnew != '0));

  // E is the younger producer, so it wins over M when both are ready.
  always_comb begin
    fwd_sel = FWD_RF;
    if (hit_e && (e_tnew == '0)) begin
      fwd_sel = FWD_E;
    end else if (hit_m && (m_tnew == '0)) begin
      fwd_sel = FWD_M;
    end
  end

endmodule

// File: rtl/d_branch_sched.sv
// d_branch_sched
// Decode-stage branch scheduler: picks forwarding sources for the two
// equality-comparator operands, stalls D while an operand is in flight, turns
// cmp_eq into a beq/bne taken decision, and runs a stall watchdog.
// Optional feature macro: BR_SCHED_STATS_EN (adds branch/taken/stall counters).
// Ports:
//   clk, reset (async, active-low)
//   d_valid, d_is_branch, d_is_bne, d_rs, d_rt   D-stage instruction info
//   e_wa, e_tnew, m_wa, m_tnew                    E/M producer info
//   cmp_eq                                        comparator equality result
//   fwd_sel_rs, fwd_sel_rt                        operand source (0 RF/1 E/2 M)
//   stall, br_taken                               combinational decisions
//   br_resolved                                   registered resolve pulse
//   wd_err                                        sticky watchdog error
//   stat_branches, stat_taken, stat_stall_cycles  (BR_SCHED_STATS_EN only)
module d_branch_sched
  import d_branch_sched_pkg::*;
#(
  parameter int MAX_STALL = 3,
  parameter int TNEW_W    = TNEW_WIDTH
`ifdef BR_SCHED_STATS_EN
  , parameter int CNT_W   = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic              d_is_branch,
  input  logic              d_is_bne,
  input  logic [4:0]        d_rs,
  input  logic [4:0]        d_rt,
  input  logic [4:0]        e_wa,
  input  logic [TNEW_W-1:0] e_tnew,
  input  logic [4:0]        m_wa,
  input  logic [TNEW_W-1:0] m_tnew,
  input  logic              cmp_eq,
  output logic [1:0]        fwd_sel_rs,
  output logic [1:0]        fwd_sel_rt,
  output logic              stall,
  output logic              br_taken,
  output logic              br_resolved,
`ifdef BR_SCHED_STATS_EN
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_taken,
  output logic [CNT_W-1:0]  stat_stall_cycles,
`endif
  output logic              wd_err
);

  // Counter must hold MAX_STALL+1 so "would exceed" is visible as a value.
  localparam int SCNT_W = $clog2(MAX_STALL + 2);
  localparam logic [SCNT_W-1:0] SCNT_SAT = SCNT_W'(MAX_STALL + 1);
  localparam logic [SCNT_W-1:0] SCNT_LIM = SCNT_W'(MAX_STALL);

  logic              br_active;
  logic              haz_rs;
  logic              haz_rt;
  logic [1:0]        sel_rs;
  logic [1:0]        sel_rt;
  logic              stall_int;
  logic              taken_int;

  br_state_e         state_q, state_d;
  logic [SCNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic              br_resolved_q, br_resolved_d;
  logic              wd_err_q, wd_err_d;

  d_fwd_pick #(.TNEW_W(TNEW_W)) u_pick_rs (
    .src     (d_rs),
    .e_wa    (e_wa),
    .e_tnew  (e_tnew),
    .m_wa    (m_wa),
    .m_tnew  (m_tnew),
    .hazard  (haz_rs),
    .fwd_sel (sel_rs)
  );

  d_fwd_pick #(.TNEW_W(TNEW_W)) u_pick_rt (
    .src     (d_rt),
    .e_wa    (e_wa),
    .e_tnew  (e_tnew),
    .m_wa    (m_wa),
    .m_tnew  (m_tnew),
    .hazard  (haz_rt),
    .fwd_sel (sel_rt)
  );

  assign br_active = d_valid & d_is_branch;

  // Stall and taken are gated by reset so the PC logic never sees a redirect
  // or freeze while the scheduler is held in reset.
  assign stall_int = reset & br_active & (haz_rs | haz_rt);
  assign taken_int = reset & br_active & ~stall_int & (cmp_eq ^ d_is_bne);

  assign stall       = stall_int;
  assign br_taken    = taken_int;
  assign fwd_sel_rs  = br_active ? sel_rs : FWD_RF;
  assign fwd_sel_rt  = br_active ? sel_rt : FWD_RF;
  assign br_resolved = br_resolved_q;
  assign wd_err      = wd_err_q;

  // Next-state logic: stall_cnt tracks consecutive stall cycles of the held
  // branch and saturates one past MAX_STALL, which is what trips the watchdog.
  always_comb begin
    state_d       = state_q;
    stall_cnt_d   = stall_cnt_q;
    br_resolved_d = br_active & ~stall_int;
    if (!br_active) begin
      state_d     = IDLE;
      stall_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE, RESOLVE: begin
          if (stall_int) begin
            state_d     = WAIT;
            stall_cnt_d = SCNT_W'(1);
          end else begin
            state_d     = IDLE;
            stall_cnt_d = '0;
          end
        end
        WAIT: begin
          if (stall_int) begin
            state_d     = WAIT;
            stall_cnt_d = (stall_cnt_q >= SCNT_SAT) ? SCNT_SAT : stall_cnt_q + 1'b1;
          end else begin
            state_d     = RESOLVE;
            stall_cnt_d = '0;
          end
        end
        default: begin
          state_d     = IDLE;
          stall_cnt_d = '0;
        end
      endcase
    end
    wd_err_d = wd_err_q | (stall_cnt_d > SCNT_LIM);
  end

`ifdef BR_SCHED_STATS_EN
  logic [CNT_W-1:0] stat_branches_q, stat_branches_d;
  logic [CNT_W-1:0] stat_taken_q, stat_taken_d;
  logic [CNT_W-1:0] stat_stall_q, stat_stall_d;

  // Counters wrap naturally; branches counts emitted br_resolved pulses.
  always_comb begin
    stat_branches_d = stat_branches_q + CNT_W'(br_resolved_q);
    stat_taken_d    = stat_taken_q + CNT_W'(taken_int);
    stat_stall_d    = stat_stall_q + CNT_W'(stall_int);
  end

  assign stat_branches     = stat_branches_q;
  assign stat_taken        = stat_taken_q;
  assign stat_stall_cycles = stat_stall_q;
`endif

  // All scheduler state; reset abandons any held branch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      stall_cnt_q     <= '0;
      br_resolved_q   <= 1'b0;
      wd_err_q        <= 1'b0;
`ifdef BR_SCHED_STATS_EN
      stat_branches_q <= '0;
      stat_taken_q    <= '0;
      stat_stall_q    <= '0;
`endif
    end else begin
      state_q         <= state_d;
      stall_cnt_q     <= stall_cnt_d;
      br_resolved_q   <= br_resolved_d;
      wd_err_q        <= wd_err_d;
`ifdef BR_SCHED_STATS_EN
      stat_branches_q <= stat_branches_d;
      stat_taken_q    <= stat_taken_d;
      stat_stall_q    <= stat_stall_d;
`endif
    end
  end

endmodule
